// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encoding and
// the default number of settle cycles per input vector.
package truth_table_sweeper_pkg;

  localparam int SETTLE_DEFAULT = 2;
  localparam int TIMER_W        = 4;   // holds SETTLE-1 for SETTLE in 1..15
  localparam int NUM_VEC        = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/truth_table_sweeper_sweep_timer.sv
// Settle-cycle down-counter. A load sets the count. The count then runs down
// to zero and stays there. expire is high while the count is zero, so a
// load value of N-1 keeps the caller waiting for exactly N cycles.
module sweep_timer
  import truth_table_sweeper_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               expire
);

  logic [TIMER_W-1:0] cnt;

  // Load takes priority. Otherwise count down and stop at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive sweep of a 4-input combinational function. Each vector is held
// on A..D for SETTLE+1 cycles: SETTLE cycles to settle and one cycle to
// sample. f is captured into tt, and the block counts the mismatches against
// a truth table that is latched when the sweep starts.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int SETTLE = SETTLE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] exp_tt,
  input  logic        f,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt,
  output logic [4:0]  errcnt,
  output logic        mismatch
);

  localparam logic [TIMER_W-1:0] LOAD_VAL = TIMER_W'(SETTLE - 1);

  state_t      state, nxt;
  logic [3:0]  idx;
  logic [15:0] exp_q;
  logic [15:0] tt_q;
  logic [4:0]  err_q;
  logic        tmr_load, tmr_expire;
  logic        accept, last_vec;

  assign accept   = (state == ST_IDLE) && start;
  assign last_vec = (idx == 4'd15);
  // Re-arm the timer on every entry to the settle state.
  assign tmr_load = accept || ((state == ST_SAMPLE) && !last_vec);

  sweep_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (LOAD_VAL),
    .expire   (tmr_expire)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  // Next-state logic. start is ignored outside IDLE, and no request is queued.
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   if (start)      nxt = ST_SETTLE;
      ST_SETTLE: if (tmr_expire) nxt = ST_SAMPLE;
      ST_SAMPLE: nxt = last_vec ? ST_DONE : ST_SETTLE;
      ST_DONE:   nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  // Sweep datapath. The index, expected table and results are cleared on
  // accept. Sampling happens on the edge that leaves SAMPLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      exp_q <= '0;
      tt_q  <= '0;
      err_q <= '0;
    end else if (accept) begin
      idx   <= '0;
      exp_q <= exp_tt;
      tt_q  <= '0;
      err_q <= '0;
    end else if (state == ST_SAMPLE) begin
      tt_q[idx] <= f;
      if ((f != exp_q[idx]) && (err_q != 5'd16)) err_q <= err_q + 5'd1;
      if (!last_vec) idx <= idx + 4'd1;
    end
  end

  assign busy            = (state == ST_SETTLE) || (state == ST_SAMPLE);
  assign done            = (state == ST_DONE);
  assign {A, B, C, D}    = busy ? idx : 4'b0000;
  assign tt              = tt_q;
  assign errcnt          = err_q;
  assign mismatch        = (err_q != 5'd0);

endmodule
